// File: rtl/bp_fe_pkg.sv
// Shared types for the FE branch direction predictor.
// Provides the prediction mode enum, the init-sweep FSM state enum and
// the weakly-not-taken counter init value used by the reset sweep.
package bp_fe_pkg;

  // Runtime-selectable prediction mode; encoding matches mode_i.
  typedef enum logic [1:0] {
    e_bp_not_taken = 2'd0,
    e_bp_taken     = 2'd1,
    e_bp_bimodal   = 2'd2,
    e_bp_gshare    = 2'd3
  } bp_fe_pred_mode_e;

  // Init sweep FSM: table is unusable until every entry has been written.
  typedef enum logic [0:0] {
    e_init  = 1'b0,
    e_ready = 1'b1
  } bp_fe_bp_state_e;

  // Weakly-not-taken: largest value whose MSB is still 0.
  function automatic int unsigned bp_fe_wnt_init(input int unsigned cnt_width);
    return (32'd1 << (cnt_width - 32'd1)) - 32'd1;
  endfunction

endpackage

// File: rtl/bp_fe_bp_gshare_if.sv
// Predictor <-> FE bundle: prediction request/response and resolved-branch update.
// Latency: none (wires only). Backpressure: master must hold off while ready_o is low.
// Ports: mode_i, r_v_i/idx_r_i (request), predict_v_o/predict_o/predict_idx_o
// (response), w_v_i/idx_w_i/taken_i (update), ready_o (init sweep complete).
interface bp_fe_bp_gshare_if #(
  parameter int unsigned bht_idx_width_p = 9
);
  logic [1:0]                 mode_i;
  logic                       ready_o;
  logic                       r_v_i;
  logic [bht_idx_width_p-1:0] idx_r_i;
  logic                       predict_v_o;
  logic                       predict_o;
  logic [bht_idx_width_p-1:0] predict_idx_o;
  logic                       w_v_i;
  logic [bht_idx_width_p-1:0] idx_w_i;
  logic                       taken_i;

  // FE side.
  modport master (
    output mode_i, r_v_i, idx_r_i, w_v_i, idx_w_i, taken_i,
    input  ready_o, predict_v_o, predict_o, predict_idx_o
  );

  // Predictor side.
  modport slave (
    input  mode_i, r_v_i, idx_r_i, w_v_i, idx_w_i, taken_i,
    output ready_o, predict_v_o, predict_o, predict_idx_o
  );
endinterface

// File: rtl/bp_fe_bp_sat_counter.sv
// Saturating up/down counter next-value function.
// Latency: combinational. Backpressure: none.
// Ports: count_i (current), taken_i (1 = increment), count_o (saturated next value).
module bp_fe_bp_sat_counter #(
  parameter int unsigned width_p = 2
) (
  input  logic [width_p-1:0] count_i,
  input  logic               taken_i,
  output logic [width_p-1:0] count_o
);

  always_comb begin
    count_o = count_i;
    if (taken_i) begin
      if (!(&count_i)) count_o = count_i + width_p'(1);
    end else begin
      if (|count_i) count_o = count_i - width_p'(1);
    end
  end

endmodule

// File: rtl/bp_fe_bp_gshare.sv
// Direction predictor: static / bimodal / gshare over a flop table of saturating counters.
// Latency: prediction registered, 1 cycle after an accepted read; updates take effect next cycle.
// Backpressure: ready_o low during reset and the init sweep; reads/updates then are dropped.
// Ports: clk_i, reset_i (sync, active-high), bus (slave side of bp_fe_bp_gshare_if).
// The interface's bht_idx_width_p must equal this module's bht_idx_width_p.
module bp_fe_bp_gshare
  import bp_fe_pkg::*;
#(
  parameter int unsigned bht_idx_width_p   = 9,
  parameter int unsigned ghist_width_p     = 8,  // 1..bht_idx_width_p
  parameter int unsigned bp_cnt_sat_bits_p = 2   // >= 1
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  bp_fe_bp_gshare_if.slave         bus
);

  localparam int unsigned els_lp = 32'd1 << bht_idx_width_p;
  localparam logic [bp_cnt_sat_bits_p-1:0] wnt_lp =
    bp_cnt_sat_bits_p'(bp_fe_wnt_init(bp_cnt_sat_bits_p));

  bp_fe_bp_state_e              state_q, state_d;
  logic [bht_idx_width_p-1:0]   init_cnt_q, init_cnt_d;
  logic [ghist_width_p-1:0]     ghr_q, ghr_d, ghr_shift;
  logic                         predict_v_q;
  logic                         predict_q, predict_d;
  logic [bht_idx_width_p-1:0]   predict_idx_q;

  logic [bp_cnt_sat_bits_p-1:0] tbl_q [els_lp];

  bp_fe_pred_mode_e             mode;
  logic                         ready;
  logic                         rd_fire, wr_fire;
  logic [bht_idx_width_p-1:0]   ghr_ext, hash;
  logic [bp_cnt_sat_bits_p-1:0] wr_old, wr_new;
  logic                         tbl_we;
  logic [bht_idx_width_p-1:0]   tbl_waddr;
  logic [bp_cnt_sat_bits_p-1:0] tbl_wdata;

  assign mode  = bp_fe_pred_mode_e'(bus.mode_i);
  assign ready = (state_q == e_ready);

  // Reset dominates: nothing is accepted in a cycle with reset_i high.
  assign rd_fire = ready & bus.r_v_i & ~reset_i;
  assign wr_fire = ready & bus.w_v_i & ~reset_i;

  // GHR zero-extended into the low index bits; copes with ghist == idx width.
  always_comb begin
    ghr_ext                    = '0;
    ghr_ext[ghist_width_p-1:0] = ghr_q;
  end

  // Hash uses the pre-shift GHR even when an update fires in the same cycle.
  assign hash = (mode == e_bp_gshare) ? (bus.idx_r_i ^ ghr_ext) : bus.idx_r_i;

  // Table read happens before this cycle's write lands, so a same-entry
  // collision naturally returns the old counter.
  always_comb begin
    predict_d = 1'b0;
    case (mode)
      e_bp_not_taken: predict_d = 1'b0;
      e_bp_taken:     predict_d = 1'b1;
      default:        predict_d = tbl_q[hash][bp_cnt_sat_bits_p-1];
    endcase
  end

  generate
    if (ghist_width_p == 1) begin : g_ghr_one
      assign ghr_shift = bus.taken_i;
    end else begin : g_ghr_many
      assign ghr_shift = {ghr_q[ghist_width_p-2:0], bus.taken_i};
    end
  endgenerate

  assign ghr_d = wr_fire ? ghr_shift : ghr_q;

  assign wr_old = tbl_q[bus.idx_w_i];

  bp_fe_bp_sat_counter #(
    .width_p (bp_cnt_sat_bits_p)
  ) u_sat (
    .count_i (wr_old),
    .taken_i (bus.taken_i),
    .count_o (wr_new)
  );

  // Init sweep: one entry per cycle, last entry is the all-ones index.
  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    if (state_q == e_init) begin
      init_cnt_d = init_cnt_q + bht_idx_width_p'(1);
      if (&init_cnt_q) state_d = e_ready;
    end
  end

  // Single write port shared between the sweep and resolved-branch updates;
  // they never overlap because updates are only accepted once ready.
  always_comb begin
    tbl_we    = 1'b0;
    tbl_waddr = bus.idx_w_i;
    tbl_wdata = wr_new;
    if (!reset_i) begin
      if (state_q == e_init) begin
        tbl_we    = 1'b1;
        tbl_waddr = init_cnt_q;
        tbl_wdata = wnt_lp;
      end else if (wr_fire) begin
        tbl_we = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q       <= e_init;
      init_cnt_q    <= '0;
      ghr_q         <= '0;
      predict_v_q   <= 1'b0;
      predict_q     <= 1'b0;
      predict_idx_q <= '0;
    end else begin
      state_q     <= state_d;
      init_cnt_q  <= init_cnt_d;
      ghr_q       <= ghr_d;
      predict_v_q <= rd_fire;
      if (rd_fire) begin
        predict_q     <= predict_d;
        predict_idx_q <= hash;
      end
    end
  end

  // Counter storage has no reset; the sweep owns its initialisation.
  always_ff @(posedge clk_i) begin
    if (tbl_we) tbl_q[tbl_waddr] <= tbl_wdata;
  end

  assign bus.ready_o       = ready;
  assign bus.predict_v_o   = predict_v_q;
  assign bus.predict_o     = predict_q;
  assign bus.predict_idx_o = predict_idx_q;

endmodule

// File: doc/bp_fe_bp_gshare.md
Name: bp_fe_bp_gshare

Overview:
Parametrised direction predictor for the FE, generalising the static/bimodal predictor.
- Holds a table of saturating counters in flops and a global history register (GHR).
- Mode is selectable at runtime: always-not-taken, always-taken, bimodal, gshare.
- Prediction is registered (1-cycle latency). A reset sweep FSM initialises the table.
- Sits between the FE PC-generation stage and the branch-resolution feedback path.

Parameters:
- bht_idx_width_p, 9: table index width; entries els = 2**bht_idx_width_p.
- ghist_width_p, 8: GHR width; must be 1..bht_idx_width_p.
- bp_cnt_sat_bits_p, 2: counter width; must be >= 1.

Ports:
- clk_i  in  1  clock
- reset_i  in  1  synchronous, active-high reset
- mode_i  in  2  0 = always_not_taken, 1 = always_taken, 2 = bimodal, 3 = gshare
- ready_o  out  1  high when init sweep done; reads/updates accepted only when high
- r_v_i  in  1  prediction request
- idx_r_i  in  bht_idx_width_p  PC-derived index
- predict_v_o  out  1  prediction valid, one cycle after accepted r_v_i
- predict_o  out  1  predicted taken
- predict_idx_o  out  bht_idx_width_p  table index actually used; FE returns it on update
- w_v_i  in  1  resolved-branch update
- idx_w_i  in  bht_idx_width_p  table index (from predict_idx_o)
- taken_i  in  1  resolved outcome

Behaviour:
- Everything clocked on clk_i rising edge; reset_i is synchronous, active-high, and dominates all other inputs.
- FSM states: e_init, e_ready. Any cycle with reset_i high forces the next state to e_init and init_cnt to 0.
  - Reset mid-sweep restarts the sweep from entry 0.
  - Reset mid-operation discards any pending prediction.
- e_init:
  - Each cycle writes counter[init_cnt] = WNT (2**(bp_cnt_sat_bits_p-1))-1, then increments init_cnt.
  - After writing entry els-1, next state is e_ready.
  - Sweep takes exactly els cycles after reset deasserts.
  - In this state, r_v_i and w_v_i are ignored and the GHR does not shift.
- ready_o = (state == e_ready), registered. It is 0 during reset and during the sweep.
- Reset values: predict_v_o = 0, predict_o = 0, predict_idx_o = 0, GHR = 0, ready_o = 0.
- Read (ready_o high, r_v_i high): hashed index h is computed as follows.
  - Bimodal and static modes: h = idx_r_i.
  - Gshare mode: h = idx_r_i XOR {zero-extend GHR into the low bits}.
  - h is registered into predict_idx_o.
  - counter[h] MSB is registered into predict_o for modes 2 and 3. Mode 0 gives 0; mode 1 gives 1.
  - predict_v_o pulses high the next cycle. With no accepted read, predict_v_o = 0 and predict_o/predict_idx_o hold their last values.
- Update (ready_o high, w_v_i high):
  - counter[idx_w_i] saturating increment if taken_i, else saturating decrement.
  - Saturates at all-ones and at 0; no wrap.
  - GHR <= {GHR[ghist_width_p-2:0], taken_i}. If ghist_width_p == 1, GHR <= taken_i.
  - Updates occur in every mode, so switching mode mid-run needs no re-init.
- Simultaneous read and update in the same cycle:
  - Same entry: the read returns the pre-update counter.
  - Gshare hashing uses the pre-shift GHR.
- mode_i is sampled in the read cycle; a change takes effect on the next read.

Decomposition:
- bp_fe_pkg holds:
  - typedef bp_fe_pred_mode_e {e_bp_not_taken, e_bp_taken, e_bp_bimodal, e_bp_gshare};
  - the FSM state enum;
  - a function computing the WNT init value from counter width.
- Natural sub-module: bp_fe_bp_sat_counter, a combinational next-value function (count, taken) -> saturated count, width-parametrised. Instantiate it once on the write path.
- Table is a flop array, not an SRAM, so single-cycle read-modify-write needs no hazard logic.

Test Plan:
- Init and reset: deassert reset with bht_idx_width_p = 4.
  - ready_o rises exactly 16 cycles later; all counters are 1 (2-bit).
  - Reassert reset at sweep cycle 7: ready_o stays 0 for a further 16 cycles after release.
- Bimodal saturation: mode 2, idx 5.
  - Three taken updates then read: predict_o = 1, counter = 3.
  - A fourth taken update leaves counter = 3.
  - Four not-taken updates then read: predict_o = 0, counter = 0.
- Gshare hashing: mode 3, GHR driven to 0b00000101 via taken/not-taken updates, read idx_r_i = 0x0F0.
  - predict_idx_o = 0x0F5, predict_v_o high exactly 1 cycle after r_v_i.
- Static modes: mode 0, then mode 1, each with reads to trained-taken entries.
  - predict_o = 0 in mode 0, 1 in mode 1.
  - Updates still train: switch to mode 2 and verify the trained value is predicted.
- Collision: same-cycle read and taken-update to idx 3 with counter = 1.
  - predict_o = 0 (old value); a following read gives 1.
  - GHR used for the hash is the pre-shift value.
- Gating: r_v_i/w_v_i asserted during the sweep → predict_v_o stays 0, GHR stays 0, no counter changes after the sweep.
